// File: rtl/fetch_unit.sv
// Instruction-fetch sequencer: drives the PC register and imem reads, and holds one fetched
// instruction for decode. Optional halt-on-opcode-0x3F support is enabled with FETCH_HALT_EN.
module fetch_unit #(
  parameter logic [31:0] PC_INC   = 32'd4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] pc_curr,
  output logic        pc_en,
  output logic [31:0] pc_next,
  output logic        imem_ren,
  output logic [31:0] imem_addr,
  input  logic        ihit,
  input  logic [31:0] imem_load,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_npc,
  output logic        halt
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    FULL   = 2'd1
`ifdef FETCH_HALT_EN
    ,
    HALTED = 2'd2
`endif
  } state_e;

  state_e      state_q, state_d, drain_st;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_npc_q, out_npc_d;
  logic [31:0] pc_seq;
  logic        ren, en, cap;
  logic [31:0] nxt;
  logic        halt_blk, halt_op;
  logic        unused_bits;

  // Redirect targets are word aligned; the low bits are dropped on purpose.
  assign unused_bits = ^redirect_pc[1:0];

  assign pc_seq    = pc_curr + PC_INC;
  assign imem_addr = pc_curr;

`ifdef FETCH_HALT_EN
  logic halt_q, halt_d;

  assign halt_blk = halt_q;
  assign halt_op  = (imem_load[31:26] == 6'b111111);
  assign drain_st = halt_q ? HALTED : FETCH;
  assign halt     = halt_q;
`else
  assign halt_blk = 1'b0;
  assign halt_op  = 1'b0;
  assign drain_st = FETCH;
  assign halt     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    out_npc_d   = out_npc_q;
`ifdef FETCH_HALT_EN
    halt_d      = halt_q;
`endif
    en          = 1'b0;
    nxt         = pc_seq;

    // Fetch only when the output slot will be free; a pending halt stops new fetches.
    unique case (state_q)
      FETCH:   ren = 1'b1;
      FULL:    ren = out_ready && !halt_blk;
      default: ren = 1'b0;
    endcase
    cap = ren && ihit;

    if (redirect && !halt_blk) begin
      en          = 1'b1;
      nxt         = {redirect_pc[31:2], 2'b00};
      out_valid_d = 1'b0;
      state_d     = FETCH;
    end else if (cap) begin
      // A halt instruction is delivered but leaves the PC parked on its own address.
      en          = !halt_op;
      out_valid_d = 1'b1;
      out_instr_d = imem_load;
      out_pc_d    = pc_curr;
      out_npc_d   = pc_seq;
      state_d     = FULL;
`ifdef FETCH_HALT_EN
      halt_d      = halt_op;
`endif
    end else if (state_q == FULL && out_ready) begin
      out_valid_d = 1'b0;
      state_d     = drain_st;
    end

    if (!nRST) begin
      ren = 1'b0;
      en  = 1'b0;
    end
  end

  assign imem_ren = ren;
  assign pc_en    = en;
  assign pc_next  = nxt;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= FETCH;
      out_valid_q <= 1'b0;
      out_instr_q <= 32'h0;
      out_pc_q    <= RESET_PC;
      out_npc_q   <= RESET_PC + PC_INC;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
      out_npc_q   <= out_npc_d;
    end
  end

`ifdef FETCH_HALT_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) halt_q <= 1'b0;
    else       halt_q <= halt_d;
  end
`endif

  assign out_valid = out_valid_q;
  assign out_instr = out_instr_q;
  assign out_pc    = out_pc_q;
  assign out_npc   = out_npc_q;

endmodule
